databus_arbiter: RTL and testbench

- Shares one databus master port between N_REQ address/databus requesters of the SuperAddress style.
- Each requester issues bursts with a valid/ready/last per-beat handshake; the arbiter grants one requester at a time with round-robin fairness.
- The granted requester keeps the bus locked until the final beat of its burst is accepted.
- Sits between the per-unit address generators and the single external databus interface.

---
 rtl/databus_arbiter.sv | 160 ++++++++++++++++
 tb/tb_databus_arbiter.sv | 365 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/databus_arbiter.sv
// databus_arbiter: round-robin arbiter sharing one databus master port among
// N_REQ burst requesters. The winner holds the bus until the master accepts
// the last beat of its burst. Then at least one IDLE cycle follows.
// Handshake: a beat transfers on a cycle where m_valid_o && m_ready_i. Valid
// comes from the owning requester. Ready comes from the master and is routed
// back only to the owner.
// Optional build macro DATABUS_ARBITER_LEN_CHECK_EN adds a per-burst beat
// counter and a sticky err_o flag for bursts whose length disagrees with m_len_o.
module databus_arbiter #(
    parameter int N_REQ      = 4,
    parameter int AXI_ADDR_W = 32,
    parameter int LEN_W      = 8,
    parameter int DATA_W     = 32
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic [N_REQ-1:0]            req_valid_i,
    input  logic [N_REQ-1:0]            req_write_i,
    input  logic [N_REQ*AXI_ADDR_W-1:0] req_addr_i,
    input  logic [N_REQ*LEN_W-1:0]      req_len_i,
    input  logic [N_REQ*DATA_W-1:0]     req_wdata_i,
    output logic [N_REQ-1:0]            req_ready_o,
    output logic [N_REQ-1:0]            req_last_o,
    output logic [DATA_W-1:0]           req_rdata_o,
    output logic                        m_valid_o,
    input  logic                        m_ready_i,
    input  logic                        m_last_i,
    output logic                        m_write_o,
    output logic [AXI_ADDR_W-1:0]       m_addr_o,
    output logic [LEN_W-1:0]            m_len_o,
    output logic [DATA_W-1:0]           m_wdata_o,
    input  logic [DATA_W-1:0]           m_rdata_i,
    output logic [N_REQ-1:0]            grant_o,
`ifdef DATABUS_ARBITER_LEN_CHECK_EN
    output logic                        err_o,
`endif
    output logic                        busy_o
);

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic {S_IDLE, S_LOCKED} state_t;

    state_t             state_q;
    logic [N_REQ-1:0]   grant_q;
    logic               busy_q;
    logic [IDX_W-1:0]   ptr_q;
    logic [IDX_W-1:0]   owner_idx;
    logic [IDX_W-1:0]   sel_idx;
    logic               sel_found;
    logic               xfer;
    logic               xfer_last;

    // Convert the one-hot grant into the owner's index for slice selection.
    always_comb begin
        owner_idx = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant_q[i]) owner_idx = IDX_W'(i);
        end
    end

    // Round-robin pick: first valid requester after ptr_q, wrapping modulo N_REQ.
    // Scanning from the farthest offset down lets the nearest one win.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        for (int off = N_REQ; off >= 1; off--) begin
            if (req_valid_i[(int'(ptr_q) + off) % N_REQ]) begin
                sel_found = 1'b1;
                sel_idx   = IDX_W'((int'(ptr_q) + off) % N_REQ);
            end
        end
    end

    // Route the owner's request fields to the master port; everything is zero when not locked.
    always_comb begin
        m_valid_o   = 1'b0;
        m_write_o   = 1'b0;
        m_addr_o    = '0;
        m_len_o     = '0;
        m_wdata_o   = '0;
        req_ready_o = '0;
        if (state_q == S_LOCKED) begin
            m_valid_o   = req_valid_i[owner_idx];
            m_write_o   = req_write_i[owner_idx];
            m_addr_o    = req_addr_i[owner_idx*AXI_ADDR_W +: AXI_ADDR_W];
            m_len_o     = req_len_i[owner_idx*LEN_W +: LEN_W];
            m_wdata_o   = req_wdata_i[owner_idx*DATA_W +: DATA_W];
            req_ready_o = m_ready_i ? grant_q : '0;
        end
    end

    assign xfer        = m_valid_o & m_ready_i;
    assign xfer_last   = xfer & m_last_i;
    assign req_last_o  = xfer_last ? grant_q : '0;
    assign req_rdata_o = m_rdata_i;
    assign grant_o     = grant_q;
    assign busy_o      = busy_q;

    // Arbitration FSM: grant in IDLE, then hold the lock until the last beat transfers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            grant_q <= '0;
            busy_q  <= 1'b0;
            ptr_q   <= IDX_W'(N_REQ - 1);
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (sel_found) begin
                        state_q <= S_LOCKED;
                        grant_q <= N_REQ'(1) << sel_idx;
                        busy_q  <= 1'b1;
                    end
                end
                S_LOCKED: begin
                    if (xfer_last) begin
                        state_q <= S_IDLE;
                        grant_q <= '0;
                        busy_q  <= 1'b0;
                        ptr_q   <= owner_idx;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    grant_q <= '0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

`ifdef DATABUS_ARBITER_LEN_CHECK_EN
    logic [LEN_W-1:0] cnt_q;
    logic [LEN_W-1:0] cnt_inc;
    logic             err_q;

    assign cnt_inc = cnt_q + LEN_W'(1);
    assign err_o   = err_q;

    // Count beats per burst and flag a last beat that disagrees with the length field.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            if (state_q == S_IDLE && sel_found) begin
                cnt_q <= '0;
            end else if (xfer) begin
                cnt_q <= cnt_inc;
            end
            if (xfer && ((m_last_i && cnt_inc != m_len_o) ||
                         (!m_last_i && cnt_inc == m_len_o))) begin
                err_q <= 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_databus_arbiter.sv
// Self-checking bench for databus_arbiter: directed scenarios plus a random
// run against an index-level reference model of the arbitration rules.
module tb_databus_arbiter;

  localparam int N  = 4;
  localparam int AW = 32;
  localparam int LW = 8;
  localparam int DW = 32;

  logic              clk;
  logic              rst;
  logic [N-1:0]      req_valid;
  logic [N-1:0]      req_write;
  logic [N*AW-1:0]   req_addr;
  logic [N*LW-1:0]   req_len;
  logic [N*DW-1:0]   req_wdata;
  logic [N-1:0]      req_ready;
  logic [N-1:0]      req_last;
  logic [DW-1:0]     req_rdata;
  logic              m_valid;
  logic              m_ready;
  logic              m_last;
  logic              m_write;
  logic [AW-1:0]     m_addr;
  logic [LW-1:0]     m_len;
  logic [DW-1:0]     m_wdata;
  logic [DW-1:0]     m_rdata;
  logic [N-1:0]      grant;
  logic              busy;
`ifdef DATABUS_ARBITER_LEN_CHECK_EN
  logic              err;
`endif

  int pass_cnt  = 0;
  int total_cnt = 0;

  // Reference model: owner index (-1 = idle), last-served index, error flag.
  int               mdl_owner;
  int               mdl_ptr;
  logic             mdl_err;
  logic [LW-1:0]    mdl_beats;

  databus_arbiter #(.N_REQ(N), .AXI_ADDR_W(AW), .LEN_W(LW), .DATA_W(DW)) dut (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid), .req_write_i(req_write), .req_addr_i(req_addr),
    .req_len_i(req_len), .req_wdata_i(req_wdata),
    .req_ready_o(req_ready), .req_last_o(req_last), .req_rdata_o(req_rdata),
    .m_valid_o(m_valid), .m_ready_i(m_ready), .m_last_i(m_last),
    .m_write_o(m_write), .m_addr_o(m_addr), .m_len_o(m_len), .m_wdata_o(m_wdata),
    .m_rdata_i(m_rdata), .grant_o(grant),
`ifdef DATABUS_ARBITER_LEN_CHECK_EN
    .err_o(err),
`endif
    .busy_o(busy)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance the model by one clock using the inputs currently applied, then
  // step past the edge so following samples sit away from it.
  task automatic tick();
    logic          found;
    logic [LW-1:0] nb;
    logic [LW-1:0] len;
    found = 1'b0;
    if (rst) begin
      mdl_owner = -1;
      mdl_ptr   = N - 1;
      mdl_err   = 1'b0;
      mdl_beats = '0;
    end else if (mdl_owner < 0) begin
      for (int off = 1; off <= N; off++) begin
        if (!found && req_valid[(mdl_ptr + off) % N]) begin
          found     = 1'b1;
          mdl_owner = (mdl_ptr + off) % N;
          mdl_beats = '0;
        end
      end
    end else if (req_valid[mdl_owner] && m_ready) begin
      nb  = mdl_beats + 8'd1;
      len = req_len[mdl_owner*LW +: LW];
      if ((m_last && nb != len) || (!m_last && nb == len)) mdl_err = 1'b1;
      mdl_beats = nb;
      if (m_last) begin
        mdl_ptr   = mdl_owner;
        mdl_owner = -1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    req_valid = '0;
    req_write = '0;
    req_addr  = '0;
    req_len   = '0;
    req_wdata = '0;
    m_ready   = 1'b0;
    m_last    = 1'b0;
    m_rdata   = '0;
  endtask

  task automatic randomize_fields();
    for (int i = 0; i < N; i++) begin
      req_addr[i*AW +: AW]  = $urandom;
      req_len[i*LW +: LW]   = LW'($urandom_range(1, 4));
      req_wdata[i*DW +: DW] = $urandom;
      req_write[i]          = 1'($urandom_range(0, 1));
    end
    m_rdata = $urandom;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    clear_inputs();
    randomize_fields();
    m_ready = 1'b1;
    m_last  = 1'b1;
    do_reset();
    #1;
    total_cnt++; if (grant !== 4'b0) $display("FAIL rst_grant got %b exp 0000", grant); else pass_cnt++;
    total_cnt++; if (busy !== 1'b0) $display("FAIL rst_busy got %b exp 0", busy); else pass_cnt++;
    total_cnt++; if (m_valid !== 1'b0) $display("FAIL rst_m_valid got %b exp 0", m_valid); else pass_cnt++;
    total_cnt++; if (m_addr !== 32'h0) $display("FAIL rst_m_addr got %h exp 0", m_addr); else pass_cnt++;
    total_cnt++; if (m_wdata !== 32'h0 || m_len !== 8'h0 || m_write !== 1'b0)
      $display("FAIL rst_m_fields got %h/%h/%b exp 0/0/0", m_wdata, m_len, m_write); else pass_cnt++;
    total_cnt++; if (req_ready !== 4'b0 || req_last !== 4'b0)
      $display("FAIL rst_req_hs got %b/%b exp 0000/0000", req_ready, req_last); else pass_cnt++;
    total_cnt++; if (req_rdata !== m_rdata) $display("FAIL rst_rdata got %h exp %h", req_rdata, m_rdata); else pass_cnt++;
    tick();
  endtask

  task automatic test_single_burst();
    logic [N-1:0] exp_last;
    do_reset();
    randomize_fields();
    req_addr[2*AW +: AW] = 32'h2000_0040;
    req_len[2*LW +: LW]  = 8'd3;
    req_valid = 4'b0100;
    m_ready   = 1'b1;
    m_last    = 1'b0;
    #1;
    total_cnt++; if (grant !== 4'b0) $display("FAIL sb_pre_grant got %b exp 0000", grant); else pass_cnt++;
    tick();
    total_cnt++; if (grant !== 4'b0100) $display("FAIL sb_grant got %b exp 0100", grant); else pass_cnt++;
    for (int b = 0; b < 3; b++) begin
      m_last = (b == 2);
      #1;
      exp_last = (b == 2) ? 4'b0100 : 4'b0000;
      total_cnt++; if (m_valid !== 1'b1) $display("FAIL sb_valid beat %0d got %b exp 1", b, m_valid); else pass_cnt++;
      total_cnt++; if (m_addr !== 32'h2000_0040) $display("FAIL sb_addr beat %0d got %h exp 20000040", b, m_addr); else pass_cnt++;
      total_cnt++; if (m_len !== 8'd3) $display("FAIL sb_len beat %0d got %0d exp 3", b, m_len); else pass_cnt++;
      total_cnt++; if (req_ready !== 4'b0100) $display("FAIL sb_ready beat %0d got %b exp 0100", b, req_ready); else pass_cnt++;
      total_cnt++; if (req_last !== exp_last) $display("FAIL sb_last beat %0d got %b exp %b", b, req_last, exp_last); else pass_cnt++;
      tick();
    end
    req_valid = '0;
    m_last    = 1'b0;
    #1;
    total_cnt++; if (grant !== 4'b0 || busy !== 1'b0) $display("FAIL sb_end got %b/%b exp 0000/0", grant, busy); else pass_cnt++;
    tick();
  endtask

  task automatic test_round_robin();
    logic [N-1:0] exp_g;
    do_reset();
    randomize_fields();
    req_valid = 4'b1111;
    m_ready   = 1'b1;
    m_last    = 1'b1;
    for (int g = 0; g < 5; g++) begin
      #1;
      total_cnt++; if (grant !== 4'b0 || busy !== 1'b0) $display("FAIL rr_idle %0d got %b/%b exp 0000/0", g, grant, busy); else pass_cnt++;
      tick();
      exp_g = 4'b0001 << (g % N);
      total_cnt++; if (grant !== exp_g) $display("FAIL rr_grant %0d got %b exp %b", g, grant, exp_g); else pass_cnt++;
      total_cnt++; if (req_last !== exp_g) $display("FAIL rr_last %0d got %b exp %b", g, req_last, exp_g); else pass_cnt++;
      tick();
    end
  endtask

  task automatic test_owner_drop();
    do_reset();
    randomize_fields();
    req_valid = 4'b0010;
    m_ready   = 1'b1;
    m_last    = 1'b0;
    tick();
    total_cnt++; if (grant !== 4'b0010 || m_valid !== 1'b1) $display("FAIL od_start got %b/%b exp 0010/1", grant, m_valid); else pass_cnt++;
    tick();
    for (int c = 0; c < 2; c++) begin
      req_valid = 4'b1000;
      #1;
      total_cnt++; if (m_valid !== 1'b0) $display("FAIL od_stall_valid %0d got %b exp 0", c, m_valid); else pass_cnt++;
      total_cnt++; if (grant !== 4'b0010) $display("FAIL od_stall_grant %0d got %b exp 0010", c, grant); else pass_cnt++;
      total_cnt++; if (req_last !== 4'b0) $display("FAIL od_stall_last %0d got %b exp 0000", c, req_last); else pass_cnt++;
      tick();
    end
    req_valid = 4'b1010;
    m_last    = 1'b1;
    #1;
    total_cnt++; if (req_last !== 4'b0010) $display("FAIL od_last got %b exp 0010", req_last); else pass_cnt++;
    tick();
    req_valid = 4'b1000;
    m_last    = 1'b0;
    #1;
    total_cnt++; if (grant !== 4'b0) $display("FAIL od_gap got %b exp 0000", grant); else pass_cnt++;
    tick();
    total_cnt++; if (grant !== 4'b1000) $display("FAIL od_next got %b exp 1000", grant); else pass_cnt++;
    tick();
  endtask

  task automatic test_ready_stall();
    do_reset();
    randomize_fields();
    req_addr[0 +: AW] = 32'hCAFE_0100;
    req_valid = 4'b0001;
    m_ready   = 1'b0;
    m_last    = 1'b0;
    tick();
    for (int c = 0; c < 5; c++) begin
      #1;
      total_cnt++; if (req_ready !== 4'b0) $display("FAIL rs_ready %0d got %b exp 0000", c, req_ready); else pass_cnt++;
      total_cnt++; if (m_valid !== 1'b1 || m_addr !== 32'hCAFE_0100)
        $display("FAIL rs_hold %0d got %b/%h exp 1/cafe0100", c, m_valid, m_addr); else pass_cnt++;
      total_cnt++; if (grant !== 4'b0001) $display("FAIL rs_grant %0d got %b exp 0001", c, grant); else pass_cnt++;
      tick();
    end
    m_ready = 1'b1;
    m_last  = 1'b1;
    #1;
    total_cnt++; if (req_ready !== 4'b0001 || req_last !== 4'b0001)
      $display("FAIL rs_done got %b/%b exp 0001/0001", req_ready, req_last); else pass_cnt++;
    tick();
    req_valid = '0;
    #1;
    total_cnt++; if (grant !== 4'b0) $display("FAIL rs_end got %b exp 0000", grant); else pass_cnt++;
    tick();
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    randomize_fields();
    req_valid = 4'b0100;
    m_ready   = 1'b1;
    m_last    = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    req_valid = '0;
    #1;
    total_cnt++; if (grant !== 4'b0 || busy !== 1'b0) $display("FAIL rm_idle got %b/%b exp 0000/0", grant, busy); else pass_cnt++;
    total_cnt++; if (m_valid !== 1'b0) $display("FAIL rm_valid got %b exp 0", m_valid); else pass_cnt++;
    req_valid = 4'b0101;
    tick();
    total_cnt++; if (grant !== 4'b0001) $display("FAIL rm_regrant got %b exp 0001", grant); else pass_cnt++;
    tick();
  endtask

`ifdef DATABUS_ARBITER_LEN_CHECK_EN
  task automatic test_len_check();
    do_reset();
    randomize_fields();
    #1;
    total_cnt++; if (err !== 1'b0) $display("FAIL lc_reset got %b exp 0", err); else pass_cnt++;
    req_len[0 +: LW] = 8'd4;
    req_valid = 4'b0001;
    m_ready   = 1'b1;
    m_last    = 1'b0;
    tick();
    tick();
    m_last = 1'b1;
    tick();
    total_cnt++; if (err !== 1'b1) $display("FAIL lc_set got %b exp 1", err); else pass_cnt++;
    req_len[0 +: LW] = 8'd1;
    tick();
    tick();
    total_cnt++; if (err !== 1'b1) $display("FAIL lc_sticky got %b exp 1", err); else pass_cnt++;
  endtask
`endif

  task automatic test_random();
    int            own;
    logic [N-1:0]  e_grant;
    logic          e_valid;
    logic [N-1:0]  e_ready;
    logic [N-1:0]  e_last;
    logic [AW-1:0] e_addr;
    logic [LW-1:0] e_len;
    logic [DW-1:0] e_wdata;
    logic          e_write;
    clear_inputs();
    do_reset();
    for (int c = 0; c < 400; c++) begin
      randomize_fields();
      req_valid = N'($urandom_range(0, 15));
      m_ready   = ($urandom_range(0, 3) != 0);
      m_last    = ($urandom_range(0, 2) == 0);
      #1;
      own     = mdl_owner;
      e_grant = '0;
      e_valid = 1'b0;
      e_write = 1'b0;
      e_addr  = '0;
      e_len   = '0;
      e_wdata = '0;
      if (own >= 0) begin
        e_grant[own] = 1'b1;
        e_valid = req_valid[own];
        e_write = req_write[own];
        e_addr  = req_addr[own*AW +: AW];
        e_len   = req_len[own*LW +: LW];
        e_wdata = req_wdata[own*DW +: DW];
      end
      e_ready = m_ready ? e_grant : '0;
      e_last  = (e_valid && m_ready && m_last) ? e_grant : '0;
      total_cnt++; if (grant !== e_grant) $display("FAIL rnd_grant c%0d got %b exp %b", c, grant, e_grant); else pass_cnt++;
      total_cnt++; if (busy !== (own >= 0)) $display("FAIL rnd_busy c%0d got %b exp %b", c, busy, own >= 0); else pass_cnt++;
      total_cnt++; if (m_valid !== e_valid) $display("FAIL rnd_valid c%0d got %b exp %b", c, m_valid, e_valid); else pass_cnt++;
      total_cnt++; if (m_write !== e_write) $display("FAIL rnd_write c%0d got %b exp %b", c, m_write, e_write); else pass_cnt++;
      total_cnt++; if (m_addr !== e_addr) $display("FAIL rnd_addr c%0d got %h exp %h", c, m_addr, e_addr); else pass_cnt++;
      total_cnt++; if (m_len !== e_len) $display("FAIL rnd_len c%0d got %h exp %h", c, m_len, e_len); else pass_cnt++;
      total_cnt++; if (m_wdata !== e_wdata) $display("FAIL rnd_wdata c%0d got %h exp %h", c, m_wdata, e_wdata); else pass_cnt++;
      total_cnt++; if (req_ready !== e_ready) $display("FAIL rnd_ready c%0d got %b exp %b", c, req_ready, e_ready); else pass_cnt++;
      total_cnt++; if (req_last !== e_last) $display("FAIL rnd_last c%0d got %b exp %b", c, req_last, e_last); else pass_cnt++;
      total_cnt++; if (req_rdata !== m_rdata) $display("FAIL rnd_rdata c%0d got %h exp %h", c, req_rdata, m_rdata); else pass_cnt++;
`ifdef DATABUS_ARBITER_LEN_CHECK_EN
      total_cnt++; if (err !== mdl_err) $display("FAIL rnd_err c%0d got %b exp %b", c, err, mdl_err); else pass_cnt++;
`endif
      tick();
    end
  endtask

  initial begin
    rst       = 1'b1;
    mdl_owner = -1;
    mdl_ptr   = N - 1;
    mdl_err   = 1'b0;
    mdl_beats = '0;
    clear_inputs();
    test_reset();
    test_single_burst();
    test_round_robin();
    test_owner_drop();
    test_ready_stall();
    test_reset_mid_burst();
`ifdef DATABUS_ARBITER_LEN_CHECK_EN
    test_len_check();
`endif
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
